// File: rtl/simd_issue_ctl.sv
// Issue/writeback front end for the SIMD integer unit: op queue, 68-bit operand
// packing, latency-tracking tag pipe and a credit-protected result FIFO.
module simd_issue_ctl #(
    parameter int          QDEPTH    = 4,
    parameter int          RDEPTH    = 4,
    parameter int          LAT       = 2,
    parameter int          TAG_W     = 4,
    parameter logic [1:0]  PTYPE_INT = 2'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [12:0]       in_op,
    input  logic [63:0]       in_a,
    input  logic [63:0]       in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              alu_en,
    output logic [12:0]       alu_operation,
    output logic [67:0]       alu_A,
    output logic [67:0]       alu_B,
    input  logic [67:0]       alu_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic              busy
);

    localparam int QAW = $clog2(QDEPTH);
    localparam int QCW = QAW + 1;
    localparam int RAW = $clog2(RDEPTH);
    localparam int RCW = RAW + 1;
    localparam int QEW = 13 + 64 + 64 + TAG_W;
    localparam int RMW = 1 + TAG_W + 64;
    localparam logic [QCW-1:0] QCAP = QCW'(QDEPTH);
    localparam logic [RCW:0]   RCAP = (RCW + 1)'(RDEPTH);

    logic [QEW-1:0]   qmem_q [QDEPTH];
    logic [QEW-1:0]   qmem_d [QDEPTH];
    logic [QAW-1:0]   qwr_q, qwr_d, qrd_q, qrd_d;
    logic [QCW-1:0]   qcount_q, qcount_d;

    logic             alu_en_q, alu_en_d;
    logic [12:0]      alu_op_q, alu_op_d;
    logic [67:0]      alu_a_q, alu_a_d;
    logic [67:0]      alu_b_q, alu_b_d;

    logic [LAT:1]     pvld_q, pvld_d;
    logic [TAG_W-1:0] ptag_q [1:LAT];
    logic [TAG_W-1:0] ptag_d [1:LAT];

    logic [RMW-1:0]   rmem_q [RDEPTH];
    logic [RMW-1:0]   rmem_d [RDEPTH];
    logic [RAW-1:0]   rwr_q, rwr_d, rrd_q, rrd_d;
    logic [RCW-1:0]   rcount_q, rcount_d;

    logic [RCW-1:0]   inflight;
    logic [QEW-1:0]   q_head;
    logic             q_push, issue, r_push, r_pop, res_err;

    function automatic logic [67:0] pack68(input logic [63:0] x);
        return {PTYPE_INT, 1'b0, x[63:32], 1'b0, x[31:0]};
    endfunction

    always_comb begin
        in_ready = ~rst & (qcount_q < QCAP);
        q_push   = in_valid & in_ready;
        q_head   = qmem_q[qrd_q];

        inflight = '0;
        for (int i = 1; i <= LAT; i++) begin
            inflight = inflight + RCW'(pvld_q[i]);
        end

        // A slot in the result FIFO is reserved for every op in the pipe, so the
        // returning result always has somewhere to land.
        issue  = (qcount_q != '0) && (({1'b0, inflight} + {1'b0, rcount_q}) < RCAP);
        r_push = pvld_q[LAT];
        r_pop  = (rcount_q != '0) & out_ready;

        qmem_d = qmem_q;
        if (q_push) begin
            qmem_d[qwr_q] = {in_op, in_a, in_b, in_tag};
        end
        qwr_d    = q_push ? qwr_q + QAW'(1) : qwr_q;
        qrd_d    = issue  ? qrd_q + QAW'(1) : qrd_q;
        qcount_d = qcount_q + QCW'(q_push) - QCW'(issue);

        alu_en_d = issue;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        if (issue) begin
            alu_op_d = q_head[QEW-1 -: 13];
            alu_a_d  = pack68(q_head[TAG_W+127 -: 64]);
            alu_b_d  = pack68(q_head[TAG_W+63 -: 64]);
        end

        pvld_d    = pvld_q;
        ptag_d    = ptag_q;
        pvld_d[1] = issue;
        ptag_d[1] = q_head[TAG_W-1:0];
        for (int i = 2; i <= LAT; i++) begin
            pvld_d[i] = pvld_q[i-1];
            ptag_d[i] = ptag_q[i-1];
        end

        res_err = (alu_res[67:66] != PTYPE_INT) | alu_res[65] | alu_res[32];
        rmem_d  = rmem_q;
        if (r_push) begin
            rmem_d[rwr_q] = {res_err, ptag_q[LAT], alu_res[64:33], alu_res[31:0]};
        end
        rwr_d    = r_push ? rwr_q + RAW'(1) : rwr_q;
        rrd_d    = r_pop  ? rrd_q + RAW'(1) : rrd_q;
        rcount_d = rcount_q + RCW'(r_push) - RCW'(r_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qwr_q    <= '0;
            qrd_q    <= '0;
            qcount_q <= '0;
            alu_en_q <= 1'b0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            pvld_q   <= '0;
            rwr_q    <= '0;
            rrd_q    <= '0;
            rcount_q <= '0;
        end else begin
            qwr_q    <= qwr_d;
            qrd_q    <= qrd_d;
            qcount_q <= qcount_d;
            alu_en_q <= alu_en_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            pvld_q   <= pvld_d;
            rwr_q    <= rwr_d;
            rrd_q    <= rrd_d;
            rcount_q <= rcount_d;
        end
    end

    // Storage is only meaningful under a valid count or stage, so it needs no reset.
    always_ff @(posedge clk) begin
        qmem_q <= qmem_d;
        ptag_q <= ptag_d;
        rmem_q <= rmem_d;
    end

    assign alu_en        = alu_en_q;
    assign alu_operation = alu_op_q;
    assign alu_A         = alu_a_q;
    assign alu_B         = alu_b_q;
    assign out_valid     = rcount_q != '0;
    assign {out_err, out_tag, out_data} = rmem_q[rrd_q];
    assign busy          = (qcount_q != '0) | (inflight != '0) | (rcount_q != '0);

endmodule

// File: tb/tb_simd_issue_ctl.sv
// Scoreboard bench for simd_issue_ctl with a LAT=2 behavioural SIMD unit model
// and a 64-bit reference model of the expected results.
module tb_simd_issue_ctl;

    localparam int         QDEPTH = 4;
    localparam int         RDEPTH = 4;
    localparam int         LAT    = 2;
    localparam int         TAG_W  = 4;
    localparam logic [1:0] PTYPE  = 2'd1;

    localparam logic [12:0] OP_PAND = 13'h0041;
    localparam logic [12:0] OP_POR  = 13'h0042;
    localparam logic [12:0] OP_PXOR = 13'h0043;
    localparam logic [12:0] OP_PSUB = 13'h0044;
    localparam logic [12:0] OP_ERRT = 13'h1F00;
    localparam logic [12:0] OP_ERRP = 13'h1F01;

    typedef struct {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } res_t;

    typedef struct {
        logic [12:0] op;
        logic [67:0] a;
        logic [67:0] b;
    } iss_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [12:0]      in_op = '0;
    logic [63:0]      in_a = '0;
    logic [63:0]      in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             alu_en;
    logic [12:0]      alu_operation;
    logic [67:0]      alu_A;
    logic [67:0]      alu_B;
    logic [67:0]      alu_res = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [63:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic             busy;

    int   nChecks = 0;
    int   nPass   = 0;
    res_t expQ[$];
    iss_t issQ[$];
    bit   readyRandom = 1'b0;
    bit   readyFixed  = 1'b1;
    int   enRun = 0, maxEnRun = 0, outRun = 0, maxOutRun = 0, nErrSeen = 0;

    simd_issue_ctl #(
        .QDEPTH(QDEPTH), .RDEPTH(RDEPTH), .LAT(LAT), .TAG_W(TAG_W), .PTYPE_INT(PTYPE)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .alu_en(alu_en), .alu_operation(alu_operation), .alu_A(alu_A), .alu_B(alu_B),
        .alu_res(alu_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [67:0] tpack(input logic [63:0] x);
        return {PTYPE, 1'b0, x[63:32], 1'b0, x[31:0]};
    endfunction

    function automatic logic [63:0] refOp(input logic [12:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            OP_POR:  return a | b;
            OP_PXOR: return a ^ b;
            OP_PSUB: return a - b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [67:0] aluModel(input logic [12:0] op, input logic [67:0] pa, input logic [67:0] pb);
        logic [67:0] r;
        r = tpack(refOp(op, {pa[64:33], pa[31:0]}, {pb[64:33], pb[31:0]}));
        if (op == OP_ERRT) r[67:66] = PTYPE ^ 2'b11;
        if (op == OP_ERRP) r[32] = 1'b1;
        return r;
    endfunction

    function automatic logic [12:0] randOp();
        case ($urandom_range(0, 9))
            0, 1:    return OP_PAND;
            2, 3:    return OP_POR;
            4, 5:    return OP_PXOR;
            6, 7:    return OP_PSUB;
            8:       return OP_ERRT;
            default: return OP_ERRP;
        endcase
    endfunction

    // The unit returns its result one cycle after the alu_en cycle, so it is
    // sampled LAT edges after the edge that raised alu_en.
    always @(posedge clk) begin
        if (alu_en) alu_res <= aluModel(alu_operation, alu_A, alu_B);
    end

    always @(posedge clk) begin
        #2;
        out_ready = readyRandom ? 1'($urandom_range(0, 1)) : readyFixed;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: captures accepted requests and checks issues and results.
    always @(negedge clk) begin
        res_t r;
        iss_t s;
        if (rst) begin
            expQ.delete();
            issQ.delete();
            enRun  = 0;
            outRun = 0;
        end else begin
            if (in_valid && in_ready) begin
                r.data = refOp(in_op, in_a, in_b);
                r.tag  = in_tag;
                r.err  = (in_op == OP_ERRT) || (in_op == OP_ERRP);
                expQ.push_back(r);
                s.op = in_op;
                s.a  = tpack(in_a);
                s.b  = tpack(in_b);
                issQ.push_back(s);
            end
            if (alu_en) begin
                checkOutput("issue_expected", 128'(issQ.size() != 0), 128'(1));
                if (issQ.size() != 0) begin
                    s = issQ.pop_front();
                    checkOutput("alu_operation", 128'(alu_operation), 128'(s.op));
                    checkOutput("alu_A", 128'(alu_A), 128'(s.a));
                    checkOutput("alu_B", 128'(alu_B), 128'(s.b));
                end
                enRun++;
            end else begin
                enRun = 0;
            end
            if (enRun > maxEnRun) maxEnRun = enRun;
            if (out_valid && out_ready) begin
                checkOutput("result_expected", 128'(expQ.size() != 0), 128'(1));
                if (expQ.size() != 0) begin
                    r = expQ.pop_front();
                    checkOutput("out_data", 128'(out_data), 128'(r.data));
                    checkOutput("out_tag", 128'(out_tag), 128'(r.tag));
                    checkOutput("out_err", 128'(out_err), 128'(r.err));
                end
                if (out_err) nErrSeen++;
                outRun++;
            end else begin
                outRun = 0;
            end
            if (outRun > maxOutRun) maxOutRun = outRun;
        end
    end

    // Offers one request, holding it until accepted or maxWait cycles pass.
    task automatic applyStimulus(input logic [12:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic [TAG_W-1:0] tag, input int maxWait, output bit accepted);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        accepted = 1'b0;
        for (int n = 0; n < maxWait && !accepted; n++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitIdle(input string name);
        int n;
        readyRandom = 1'b0;
        readyFixed  = 1'b1;
        n = 0;
        while (n < 400 && !(expQ.size() == 0 && issQ.size() == 0 && !busy)) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, 128'(n < 400), 128'(1));
    endtask

    initial begin
        #(60000 * 10);
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        int nAcc, n;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
        checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_alu_en", 128'(alu_en), 128'(0));
        checkOutput("rst_alu_A", 128'(alu_A), 128'(0));
        checkOutput("rst_alu_op", 128'(alu_operation), 128'(0));
        rst = 1'b0;
        #0;
        checkOutput("in_ready_after_rst", 128'(in_ready), 128'(1));

        $display("[TB] single op");
        applyStimulus(OP_PAND, 64'hFFFF0000_12345678, 64'h0F0F0F0F_FFFFFFFF, 4'd3, 5, acc);
        in_valid = 1'b0;
        checkOutput("single_accept", 128'(acc), 128'(1));
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("single_latency_edges", 128'(n), 128'(LAT + 1));
        checkOutput("single_data", 128'(out_data), 128'(64'h0F0F0000_12345678));
        checkOutput("single_tag", 128'(out_tag), 128'(3));
        checkOutput("single_err", 128'(out_err), 128'(0));
        waitIdle("single_idle");

        $display("[TB] streaming");
        maxEnRun  = 0;
        maxOutRun = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(randOp(), {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'(i), 5, acc);
        end
        in_valid = 1'b0;
        waitIdle("stream_idle");
        checkOutput("stream_alu_en_run", 128'(maxEnRun), 128'(8));
        checkOutput("stream_out_run", 128'(maxOutRun), 128'(8));

        $display("[TB] format errors");
        nErrSeen = 0;
        applyStimulus(OP_ERRT, {$urandom, $urandom}, {$urandom, $urandom}, 4'd1, 5, acc);
        applyStimulus(OP_PXOR, {$urandom, $urandom}, {$urandom, $urandom}, 4'd2, 5, acc);
        applyStimulus(OP_ERRP, {$urandom, $urandom}, {$urandom, $urandom}, 4'd3, 5, acc);
        in_valid = 1'b0;
        waitIdle("err_idle");
        checkOutput("err_count", 128'(nErrSeen), 128'(2));

        $display("[TB] backpressure");
        readyFixed = 1'b0;
        nAcc = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(randOp(), {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'(i), 3, acc);
            if (acc) nAcc++;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_accepts", 128'(nAcc), 128'(QDEPTH + RDEPTH));
        checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
        checkOutput("bp_out_valid", 128'(out_valid), 128'(1));
        checkOutput("bp_alu_en_idle", 128'(alu_en), 128'(0));
        checkOutput("bp_sb_depth", 128'(expQ.size()), 128'(8));
        waitIdle("bp_drain");

        $display("[TB] reset mid-flight");
        readyFixed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(randOp(), {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'(i), 3, acc);
        end
        in_valid = 1'b0;
        checkOutput("mid_busy_before", 128'(busy), 128'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_busy", 128'(busy), 128'(0));
        checkOutput("mid_out_valid", 128'(out_valid), 128'(0));
        checkOutput("mid_alu_en", 128'(alu_en), 128'(0));
        checkOutput("mid_in_ready_in_rst", 128'(in_ready), 128'(0));
        rst = 1'b0;
        readyFixed = 1'b1;
        #0;
        checkOutput("mid_in_ready", 128'(in_ready), 128'(1));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checkOutput("mid_no_valid", 128'(out_valid), 128'(0));
        end

        $display("[TB] push/pop at full");
        readyFixed = 1'b0;
        nAcc = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(randOp(), {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'(i), 3, acc);
            if (acc) nAcc++;
        end
        checkOutput("full_fill", 128'(nAcc), 128'(8));
        readyFixed = 1'b1;
        nAcc = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(randOp(), {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'(i + 8), 10, acc);
            if (acc) nAcc++;
        end
        in_valid = 1'b0;
        checkOutput("full_stream_accepts", 128'(nAcc), 128'(12));
        waitIdle("full_idle");

        $display("[TB] random traffic");
        readyRandom = 1'b1;
        nAcc = 0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            applyStimulus(randOp(), {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'(i), 50, acc);
            if (acc) nAcc++;
        end
        in_valid = 1'b0;
        checkOutput("rand_accepts", 128'(nAcc), 128'(40));
        waitIdle("rand_idle");
        checkOutput("final_out_valid", 128'(out_valid), 128'(0));
        checkOutput("final_busy", 128'(busy), 128'(0));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
